// File: rtl/vga_pkg.sv
// Shared scan-state type and default 640x480 timing, also consumed by the VGA sync block.
package vga_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int VGA_CNT_W         = 10;
   localparam int VGA_TOTAL_COLS    = 800;
   localparam int VGA_TOTAL_ROWS    = 525;
   localparam int VGA_ACTIVE_COLS   = 640;
   localparam int VGA_ACTIVE_ROWS   = 480;

endpackage

// File: rtl/vga_mode_table.sv
// Selects the totals/actives of the mode currently in effect; purely combinational.
module vga_mode_table #(
   parameter int CNT_W          = 10,
   parameter int M0_TOTAL_COLS  = 800,
   parameter int M0_TOTAL_ROWS  = 525,
   parameter int M0_ACTIVE_COLS = 640,
   parameter int M0_ACTIVE_ROWS = 480,
   parameter int M1_TOTAL_COLS  = 800,
   parameter int M1_TOTAL_ROWS  = 449,
   parameter int M1_ACTIVE_COLS = 640,
   parameter int M1_ACTIVE_ROWS = 400
) (
   input  logic             mode,
   output logic [CNT_W-1:0] total_cols,
   output logic [CNT_W-1:0] total_rows,
   output logic [CNT_W-1:0] active_cols,
   output logic [CNT_W-1:0] active_rows
);

   assign total_cols  = mode ? CNT_W'(M1_TOTAL_COLS)  : CNT_W'(M0_TOTAL_COLS);
   assign total_rows  = mode ? CNT_W'(M1_TOTAL_ROWS)  : CNT_W'(M0_TOTAL_ROWS);
   assign active_cols = mode ? CNT_W'(M1_ACTIVE_COLS) : CNT_W'(M0_ACTIVE_COLS);
   assign active_rows = mode ? CNT_W'(M1_ACTIVE_ROWS) : CNT_W'(M0_ACTIVE_ROWS);

endmodule

// File: rtl/vga_timing_ctrl.sv
// Scan controller: column/row counters, start/stop and mode switching at frame boundaries,
// plus line/frame strobes for downstream renderers.
module vga_timing_ctrl
   import vga_pkg::*;
#(
   parameter int CNT_W          = VGA_CNT_W,
   parameter int M0_TOTAL_COLS  = VGA_TOTAL_COLS,
   parameter int M0_TOTAL_ROWS  = VGA_TOTAL_ROWS,
   parameter int M0_ACTIVE_COLS = VGA_ACTIVE_COLS,
   parameter int M0_ACTIVE_ROWS = VGA_ACTIVE_ROWS,
   parameter int M1_TOTAL_COLS  = 800,
   parameter int M1_TOTAL_ROWS  = 449,
   parameter int M1_ACTIVE_COLS = 640,
   parameter int M1_ACTIVE_ROWS = 400
) (
   input  logic             i_Clk,
   input  logic             i_Rst_L,
   input  logic             i_Enable,
   input  logic             i_Mode_Req,
   input  logic             i_Mode_Sel,
   output logic [CNT_W-1:0] o_Col_Count,
   output logic [CNT_W-1:0] o_Row_Count,
   output logic             o_Active,
   output logic             o_Line_Start,
   output logic             o_Frame_Start,
   output logic             o_Running,
   output logic             o_Mode,
   output logic             o_Mode_Ack,
   output logic [7:0]       o_Frame_Count
);

   if (M0_TOTAL_COLS >= 2**CNT_W || M0_TOTAL_ROWS >= 2**CNT_W ||
       M1_TOTAL_COLS >= 2**CNT_W || M1_TOTAL_ROWS >= 2**CNT_W) begin : g_width_check
      $error("vga_timing_ctrl: a timing total does not fit in CNT_W bits");
   end

   state_t           state;
   logic [CNT_W-1:0] col;
   logic [CNT_W-1:0] row;
   logic             mode;
   logic             pend;
   logic             target;
   logic             ack;
   logic [7:0]       frame_cnt;

   logic [CNT_W-1:0] tc, tr, ac, ar;

   vga_mode_table #(
      .CNT_W          (CNT_W),
      .M0_TOTAL_COLS  (M0_TOTAL_COLS),
      .M0_TOTAL_ROWS  (M0_TOTAL_ROWS),
      .M0_ACTIVE_COLS (M0_ACTIVE_COLS),
      .M0_ACTIVE_ROWS (M0_ACTIVE_ROWS),
      .M1_TOTAL_COLS  (M1_TOTAL_COLS),
      .M1_TOTAL_ROWS  (M1_TOTAL_ROWS),
      .M1_ACTIVE_COLS (M1_ACTIVE_COLS),
      .M1_ACTIVE_ROWS (M1_ACTIVE_ROWS)
   ) u_mode_table (
      .mode        (mode),
      .total_cols  (tc),
      .total_rows  (tr),
      .active_cols (ac),
      .active_rows (ar)
   );

   logic at_line_end;
   logic at_frame_end;
   logic apply_mode;
   logic next_target;

   assign at_line_end  = (state == RUN) && (col == tc - CNT_W'(1));
   assign at_frame_end = at_line_end && (row == tr - CNT_W'(1));

   // A request sampled on the boundary edge itself (or in IDLE) takes effect on that same edge.
   assign apply_mode  = (pend || i_Mode_Req) && ((state == IDLE) || at_frame_end);
   assign next_target = i_Mode_Req ? i_Mode_Sel : target;

   // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         mode   <= 1'b0;
         pend   <= 1'b0;
         target <= 1'b0;
         ack    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         ack <= apply_mode;
         if (apply_mode) begin
            mode <= next_target;
            pend <= 1'b0;
         end else if (i_Mode_Req) begin
            pend   <= 1'b1;
            target <= i_Mode_Sel;
         end
      end
   end

   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         state     <= IDLE;
         col       <= '0;
         row       <= '0;
         frame_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               col <= '0;
               row <= '0;
               if (i_Enable) state <= RUN;
            end
            RUN: begin
               if (at_frame_end) begin
                  col       <= '0;
                  row       <= '0;
                  frame_cnt <= frame_cnt + 8'd1;
                  if (!i_Enable) state <= IDLE;
               end else if (at_line_end) begin
                  col <= '0;
                  row <= row + CNT_W'(1);
               end else begin
                  col <= col + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign o_Col_Count   = col;
   assign o_Row_Count   = row;
   assign o_Running     = (state == RUN);
   assign o_Active      = o_Running && (col < ac) && (row < ar);
   assign o_Line_Start  = o_Running && (col == '0);
   assign o_Frame_Start = o_Line_Start && (row == '0);
   assign o_Mode        = mode;
   assign o_Mode_Ack    = ack;
   assign o_Frame_Count = frame_cnt;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl with small geometries, compared every cycle against a
// frame-position model plus directed boundary scenarios and a randomized phase.
module tb_vga_timing_ctrl;

   localparam int W   = 4;
   localparam int TC0 = 8, TR0 = 4, AC0 = 6, AR0 = 3;
   localparam int TC1 = 6, TR1 = 5, AC1 = 4, AR1 = 3;

   logic         clk = 1'b0;
   logic         rst_l = 1'b0;
   logic         en = 1'b0;
   logic         req = 1'b0;
   logic         sel = 1'b0;
   logic [W-1:0] col_o, row_o;
   logic         active_o, line_o, frame_o, run_o, mode_o, ack_o;
   logic [7:0]   fc_o;

   int checks = 0;
   int errors = 0;

   // reference model: position within frame as a single pixel index
   bit m_run, m_mode, m_pend, m_tgt, m_ack;
   int m_pos, m_fc;

   vga_timing_ctrl #(
      .CNT_W (W),
      .M0_TOTAL_COLS (TC0), .M0_TOTAL_ROWS (TR0), .M0_ACTIVE_COLS (AC0), .M0_ACTIVE_ROWS (AR0),
      .M1_TOTAL_COLS (TC1), .M1_TOTAL_ROWS (TR1), .M1_ACTIVE_COLS (AC1), .M1_ACTIVE_ROWS (AR1)
   ) dut (
      .i_Clk (clk), .i_Rst_L (rst_l), .i_Enable (en), .i_Mode_Req (req), .i_Mode_Sel (sel),
      .o_Col_Count (col_o), .o_Row_Count (row_o), .o_Active (active_o),
      .o_Line_Start (line_o), .o_Frame_Start (frame_o), .o_Running (run_o),
      .o_Mode (mode_o), .o_Mode_Ack (ack_o), .o_Frame_Count (fc_o)
   );

   always #5 clk = ~clk;

   function automatic int tc_of(bit m); return m ? TC1 : TC0; endfunction
   function automatic int tr_of(bit m); return m ? TR1 : TR0; endfunction
   function automatic int ac_of(bit m); return m ? AC1 : AC0; endfunction
   function automatic int ar_of(bit m); return m ? AR1 : AR0; endfunction
   function automatic int m_col(); return m_run ? m_pos % tc_of(m_mode) : 0; endfunction
   function automatic int m_row(); return m_run ? m_pos / tc_of(m_mode) : 0; endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input bit r, input bit e, input bit q, input bit s);
      bit boundary, new_mode;
      if (!r) begin
         m_run = 0; m_pos = 0; m_mode = 0; m_pend = 0; m_tgt = 0; m_ack = 0; m_fc = 0;
         return;
      end
      boundary = m_run && (m_pos == tc_of(m_mode) * tr_of(m_mode) - 1);
      new_mode = m_mode;
      m_ack = 0;
      if ((m_pend || q) && (!m_run || boundary)) begin
         new_mode = q ? s : m_tgt;
         m_pend = 0;
         m_ack = 1;
      end else if (q) begin
         m_pend = 1;
         m_tgt = s;
      end
      if (m_run) begin
         if (boundary) begin
            m_pos = 0;
            m_fc = (m_fc + 1) % 256;
            if (!e) m_run = 0;
         end else begin
            m_pos++;
         end
      end else if (e) begin
         m_run = 1;
         m_pos = 0;
      end
      m_mode = new_mode;
   endtask

   task automatic check_all();
      int c, r;
      c = m_col();
      r = m_row();
      check("col", 32'(col_o), c);
      check("row", 32'(row_o), r);
      check("running", 32'(run_o), 32'(m_run));
      check("active", 32'(active_o), 32'(m_run && c < ac_of(m_mode) && r < ar_of(m_mode)));
      check("line_start", 32'(line_o), 32'(m_run && c == 0));
      check("frame_start", 32'(frame_o), 32'(m_run && c == 0 && r == 0));
      check("mode", 32'(mode_o), 32'(m_mode));
      check("mode_ack", 32'(ack_o), 32'(m_ack));
      check("frame_count", 32'(fc_o), m_fc);
   endtask

   task automatic step(input bit r, input bit e, input bit q, input bit s);
      rst_l = r; en = e; req = q; sel = s;
      @(posedge clk);
      model_edge(r, e, q, s);
      #1;
      check_all();
   endtask

   // advance (scanning, no requests) until the model sits at the given column/row
   task automatic run_to(input int c, input int r);
      int n = 0;
      while (!(m_run && m_col() == c && m_row() == r) && n < 200) begin
         step(1, 1, 0, 0);
         n++;
      end
      check("run_to_reached", 32'(n < 200), 1);
   endtask

   initial begin
      int act, n, acks;

      // reset held for three cycles
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0);

      // start: first RUN cycle shows frame start, 18 active pixels per 8x4 frame
      step(1, 1, 0, 0);
      check("start_frame_strobe", 32'(frame_o), 1);
      act = int'(active_o);
      for (int i = 0; i < 31; i++) begin
         step(1, 1, 0, 0);
         act += int'(active_o);
      end
      check("active_per_frame", act, 18);
      step(1, 1, 0, 0);
      check("frames_after_32", 32'(fc_o), 1);

      // stop at row1 col3 finishes the frame: 21 more edges until IDLE
      run_to(3, 1);
      n = 0;
      while (m_run && n < 100) begin
         step(1, 0, 0, 0);
         n++;
      end
      check("stop_len", n, 21);
      check("stopped_col", 32'(col_o), 0);

      // stop cancelled by re-enabling before the boundary
      step(1, 1, 0, 0);
      run_to(3, 1);
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
      run_to(0, 0);
      check("stop_cancelled", 32'(run_o), 1);

      // mode 1 requested mid-frame: one ack at the boundary, next frame lasts 30 cycles
      run_to(0, 2);
      step(1, 1, 1, 1);
      acks = 0;
      n = 0;
      while (m_pos != 0 && n < 100) begin
         check("mode_held", 32'(mode_o), 0);
         step(1, 1, 0, 0);
         acks += int'(ack_o);
         n++;
      end
      check("mode_change_acks", acks, 1);
      check("mode_now_1", 32'(mode_o), 1);
      n = 0;
      do begin
         step(1, 1, 0, 0);
         n++;
      end while (m_pos != 0 && n < 100);
      check("mode1_frame_len", n, 30);

      // back-to-back requests collapse to a single ack
      run_to(0, 1);
      step(1, 1, 1, 1);
      step(1, 1, 0, 0);
      step(1, 1, 1, 0);
      acks = 0;
      n = 0;
      while (m_pos != 0 && n < 100) begin
         step(1, 1, 0, 0);
         acks += int'(ack_o);
         n++;
      end
      check("b2b_acks", acks, 1);
      check("b2b_mode", 32'(mode_o), 0);

      // request and stop on the boundary edge itself
      run_to(TC0 - 1, TR0 - 1);
      step(1, 0, 1, 1);
      check("bnd_idle", 32'(run_o), 0);
      check("bnd_mode", 32'(mode_o), 1);
      check("bnd_ack", 32'(ack_o), 1);
      step(1, 0, 0, 0);
      check("bnd_ack_once", 32'(ack_o), 0);

      // request while idle is acknowledged on the next cycle
      step(1, 0, 1, 0);
      check("idle_ack", 32'(ack_o), 1);
      check("idle_mode", 32'(mode_o), 0);

      // reset mid-frame with a request pending
      step(1, 1, 0, 0);
      run_to(5, 2);
      step(1, 1, 1, 1);
      step(0, 1, 1, 1);
      check("rst_ack", 32'(ack_o), 0);
      check("rst_col", 32'(col_o), 0);
      check("rst_running", 32'(run_o), 0);
      step(1, 0, 0, 0);
      check("rst_pend_cleared", 32'(ack_o), 0);

      // randomized traffic against the model
      for (int i = 0; i < 4000; i++)
         step($urandom_range(0, 299) != 0, $urandom_range(0, 11) != 0,
              $urandom_range(0, 24) == 0, 1'($urandom_range(0, 1)));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
